// File: rtl/esm_issue_feeder_pkg.sv
// Shared definitions for the ESM issue feeder: opcode constants, FSM states and the
// opcode decoder used to derive RegWrite/ALUSrc.
package esm_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned BUBBLE = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } feeder_state_e;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic bad_opc;
    } dec_t;

    // rd==0 masking and the all-zero bubble exception are applied by the caller.
    function automatic dec_t decode_opcode(input logic [6:0] opc);
        dec_t d;
        d = '0;
        unique case (opc)
            OPC_R:      d.reg_write = 1'b1;
            OPC_IMM,
            OPC_LOAD,
            OPC_LUI:    begin
                d.reg_write = 1'b1;
                d.alu_src   = 1'b1;
            end
            OPC_STORE:  d.alu_src = 1'b1;
            OPC_BRANCH: d = '0;
            default:    d.bad_opc = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/esm_issue_feeder_if.sv
// Fetch-side and ESM-side signal bundle of the issue feeder. The feeder uses the slave
// modport; the driver of fetch words and stall/flush uses the master modport.
interface esm_issue_feeder_if #(
    parameter int unsigned Instruction_word_size = 32,
    parameter int unsigned bs                    = 16
);
    localparam int unsigned CntW = $clog2(bs) + 1;

    logic                             in_valid;
    logic                             in_ready;
    logic [Instruction_word_size-1:0] in_instr;
    logic                             stall;
    logic                             flush;
    logic [Instruction_word_size-1:0] Instr_out;
    logic                             RegWrite;
    logic                             ALUSrc;
    logic                             illegal;
    logic [CntW-1:0]                  count;

    modport master (
        output in_valid, in_instr, stall, flush,
        input  in_ready, Instr_out, RegWrite, ALUSrc, illegal, count
    );

    modport slave (
        input  in_valid, in_instr, stall, flush,
        output in_ready, Instr_out, RegWrite, ALUSrc, illegal, count
    );

endinterface

// File: rtl/esm_feeder_fifo.sv
// Synchronous FIFO with occupancy count and a flush that clears pointers and count.
// Depth must be a power of two so the pointers wrap naturally.
module esm_feeder_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PtrW'(1);
            if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/esm_issue_feeder.sv
// Issue feeder ahead of ESM: buffers fetched words, decodes RegWrite/ALUSrc and issues one
// word or bubble per cycle. Optional perf counters are enabled by ESM_FEEDER_PERF_EN.
module esm_issue_feeder
    import esm_pkg::*;
#(
    parameter int unsigned Instruction_word_size = 32,
    parameter int unsigned bs                    = 16
) (
    input  logic                clk,
    input  logic                rst,
    esm_issue_feeder_if.slave   bus
`ifdef ESM_FEEDER_PERF_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_bubbles,
    output logic [31:0]         perf_stalls
`endif
);

    localparam int unsigned Iws  = Instruction_word_size;
    localparam int unsigned CntW = $clog2(bs) + 1;

    logic [Iws-1:0]  head;
    logic            full, empty;
    logic [CntW-1:0] count;
    logic            push, pop;

    logic [Iws-1:0]  instr_q, instr_d;
    logic            rw_q, rw_d;
    logic            as_q, as_d;
    logic            ill_q, ill_d;
    dec_t            dec;

    feeder_state_e   state_q, state_d;
    logic            load_word, load_bubble;

    assign push = bus.in_valid & ~full & ~bus.flush;
    assign pop  = ~bus.stall & ~empty & ~bus.flush;

    esm_feeder_fifo #(
        .Width (Iws),
        .Depth (bs)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (bus.flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.in_instr),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign bus.in_ready  = ~full;
    assign bus.count     = count;
    assign bus.Instr_out = instr_q;
    assign bus.RegWrite  = rw_q;
    assign bus.ALUSrc    = as_q;
    assign bus.illegal   = ill_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (push || count != '0) state_d = RUN;
                RUN: begin
                    if (bus.stall) begin
                        state_d = HOLD;
                    end else if (!push && (empty || (pop && count == CntW'(1)))) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (empty && !push) state_d = IDLE;
                    else if (!bus.stall) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: what the output register loads at this edge
    always_comb begin
        load_word   = pop;
        load_bubble = bus.flush | (~bus.stall & empty);
    end

    assign dec = decode_opcode(head[6:0]);

    always_comb begin
        instr_d = instr_q;
        rw_d    = rw_q;
        as_d    = as_q;
        ill_d   = ill_q;
        if (load_bubble) begin
            instr_d = Iws'(BUBBLE);
            rw_d    = 1'b0;
            as_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (load_word) begin
            instr_d = head;
            rw_d    = dec.reg_write & (head[11:7] != 5'd0);
            as_d    = dec.alu_src;
            // An all-zero word carries opcode 0 but is a bubble, not an illegal op.
            ill_d   = dec.bad_opc & (head != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            rw_q    <= 1'b0;
            as_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            rw_q    <= rw_d;
            as_q    <= as_d;
            ill_q   <= ill_d;
        end
    end

`ifdef ESM_FEEDER_PERF_EN
    logic [31:0] issued_q, bubbles_q, stalls_q;

    // Only rst clears these; a flush-induced bubble is not counted as an issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q  <= '0;
            bubbles_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (load_word)                    issued_q  <= issued_q + 32'd1;
            if (~bus.flush & ~bus.stall & empty) bubbles_q <= bubbles_q + 32'd1;
            if (bus.stall)                    stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign perf_issued  = issued_q;
    assign perf_bubbles = bubbles_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule
